// File: rtl/seven_seg_capture_if.sv
// Scanned seven-segment display bus together with the recovered-value outputs.
// The master drives the display lines (abcdefgh + one-hot digit). The slave is
// the capture block, which publishes the decoded frame.
interface seven_seg_capture_if #(
  parameter int N_DIGITS = 8
);
  logic [7:0]            abcdefgh;
  logic [7:0]            digit;
  logic [4*N_DIGITS-1:0] value;
  logic [N_DIGITS-1:0]   dp;
  logic                  value_valid;
  logic                  frame_valid;
  logic                  decode_error;
  logic [2:0]            error_digit;

  modport master (
    output abcdefgh, digit,
    input  value, dp, value_valid, frame_valid, decode_error, error_digit
  );

  modport slave (
    input  abcdefgh, digit,
    output value, dp, value_valid, frame_valid, decode_error, error_digit
  );
endinterface

// File: rtl/seven_seg_capture.sv
// Receive side of a multiplexed seven-segment bus. The digit select is
// watched until it has been stable and one-hot for SETTLE_CYCLES cycles.
// The segment pattern is then decoded back to a hex nibble and stored in a
// shadow frame. Once every digit has been captured, the frame is published
// on value/dp.
module seven_seg_capture #(
  parameter int N_DIGITS      = 8,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  seven_seg_capture_if.slave      bus
);

  localparam int             CW         = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0]  SETTLE_MAX = CW'(SETTLE_CYCLES);
  localparam int             VW         = 4 * N_DIGITS;

  // Segment pattern (dp forced to 0) back to {valid, nibble}
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    logic [4:0] r;
    case ({seg, 1'b0})
      8'hFC:   r = {1'b1, 4'h0};
      8'h60:   r = {1'b1, 4'h1};
      8'hDA:   r = {1'b1, 4'h2};
      8'hF2:   r = {1'b1, 4'h3};
      8'h66:   r = {1'b1, 4'h4};
      8'hB6:   r = {1'b1, 4'h5};
      8'hBE:   r = {1'b1, 4'h6};
      8'hE0:   r = {1'b1, 4'h7};
      8'hFE:   r = {1'b1, 4'h8};
      8'hF6:   r = {1'b1, 4'h9};
      8'hEE:   r = {1'b1, 4'hA};
      8'h3E:   r = {1'b1, 4'hB};
      8'h9C:   r = {1'b1, 4'hC};
      8'h7A:   r = {1'b1, 4'hD};
      8'h9E:   r = {1'b1, 4'hE};
      8'h8E:   r = {1'b1, 4'hF};
      default: r = {1'b0, 4'h0};
    endcase
    return r;
  endfunction

  // Index of the set bit in a one-hot digit select
  function automatic logic [2:0] onehot_index(input logic [N_DIGITS-1:0] sel);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (sel[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // Input registers and the previous-cycle copy of the digit select
  logic [7:0]          abcdefgh_q;
  logic [7:0]          digit_q;
  logic [N_DIGITS-1:0] dsel_prev_q;

  // Dwell tracking
  logic [CW-1:0]       dwell_q, dwell_d;
  logic                sampled_q, sampled_d;

  // Frame under construction
  logic [N_DIGITS-1:0] mask_q, mask_d;
  logic [VW-1:0]       shadow_val_q, shadow_val_d;
  logic [N_DIGITS-1:0] shadow_dp_q, shadow_dp_d;

  // Published results
  logic [VW-1:0]       value_q, value_d;
  logic [N_DIGITS-1:0] dp_q, dp_d;
  logic                value_valid_q, value_valid_d;
  logic                frame_valid_q, frame_valid_d;
  logic                decode_error_q, decode_error_d;
  logic [2:0]          error_digit_q, error_digit_d;

  // Combinational helpers
  logic [N_DIGITS-1:0] dsel;
  logic                onehot;
  logic                changed;
  logic                sample;
  logic [4:0]          dec;
  logic                frame_done;

  // Digit classification, dwell counting and sample-event detection
  always_comb begin
    dsel    = digit_q[N_DIGITS-1:0];
    onehot  = (dsel != '0) && ((dsel & (dsel - 1'b1)) == '0);
    changed = (dsel != dsel_prev_q);
    dec     = seg_decode(abcdefgh_q[7:1]);

    dwell_d = dwell_q;
    if (!onehot) begin
      dwell_d = '0;
    end else if (changed) begin
      dwell_d = CW'(1);
    end else if (dwell_q < SETTLE_MAX) begin
      dwell_d = dwell_q + 1'b1;
    end

    // One sample per dwell: the counter is already saturated on an unchanged
    // one-hot select and this dwell has not been sampled yet.
    sample = onehot && !changed && (dwell_q == SETTLE_MAX) && !sampled_q;

    sampled_d = sampled_q;
    if (!onehot || changed) begin
      sampled_d = 1'b0;
    end else if (sample) begin
      sampled_d = 1'b1;
    end
  end

  // Frame assembly, publication and error reporting
  always_comb begin
    frame_done     = &mask_q;

    mask_d         = mask_q;
    shadow_val_d   = shadow_val_q;
    shadow_dp_d    = shadow_dp_q;
    value_d        = value_q;
    dp_d           = dp_q;
    value_valid_d  = value_valid_q;
    frame_valid_d  = 1'b0;
    decode_error_d = 1'b0;
    error_digit_d  = error_digit_q;

    // A full mask is published one edge after the sample that completed it.
    if (frame_done) begin
      value_d       = shadow_val_q;
      dp_d          = shadow_dp_q;
      value_valid_d = 1'b1;
      frame_valid_d = 1'b1;
      mask_d        = '0;
    end

    if (sample) begin
      if (dec[4]) begin
        for (int i = 0; i < N_DIGITS; i++) begin
          if (dsel[i]) begin
            shadow_val_d[4*i +: 4] = dec[3:0];
            shadow_dp_d[i]         = abcdefgh_q[0];
            mask_d[i]              = 1'b1;
          end
        end
      end else begin
        // Unrecognised pattern: drop the partial frame and start over.
        decode_error_d = 1'b1;
        error_digit_d  = onehot_index(dsel);
        mask_d         = '0;
        shadow_val_d   = '0;
        shadow_dp_d    = '0;
      end
    end
  end

  // Input stage: register the raw bus once
  always_ff @(posedge clock) begin
    if (!reset) begin
      abcdefgh_q  <= '0;
      digit_q     <= '0;
      dsel_prev_q <= '0;
    end else begin
      abcdefgh_q  <= bus.abcdefgh;
      digit_q     <= bus.digit;
      dsel_prev_q <= dsel;
    end
  end

  // Dwell counter and per-dwell sampled flag
  always_ff @(posedge clock) begin
    if (!reset) begin
      dwell_q   <= '0;
      sampled_q <= 1'b0;
    end else begin
      dwell_q   <= dwell_d;
      sampled_q <= sampled_d;
    end
  end

  // Capture mask and shadow frame
  always_ff @(posedge clock) begin
    if (!reset) begin
      mask_q       <= '0;
      shadow_val_q <= '0;
      shadow_dp_q  <= '0;
    end else begin
      mask_q       <= mask_d;
      shadow_val_q <= shadow_val_d;
      shadow_dp_q  <= shadow_dp_d;
    end
  end

  // Published value, status pulses and error index
  always_ff @(posedge clock) begin
    if (!reset) begin
      value_q        <= '0;
      dp_q           <= '0;
      value_valid_q  <= 1'b0;
      frame_valid_q  <= 1'b0;
      decode_error_q <= 1'b0;
      error_digit_q  <= '0;
    end else begin
      value_q        <= value_d;
      dp_q           <= dp_d;
      value_valid_q  <= value_valid_d;
      frame_valid_q  <= frame_valid_d;
      decode_error_q <= decode_error_d;
      error_digit_q  <= error_digit_d;
    end
  end

  assign bus.value        = value_q;
  assign bus.dp           = dp_q;
  assign bus.value_valid  = value_valid_q;
  assign bus.frame_valid  = frame_valid_q;
  assign bus.decode_error = decode_error_q;
  assign bus.error_digit  = error_digit_q;

endmodule
